// File: rtl/gpio_link_pkg.sv
// Shared types and helpers for the GPIO link scheduler: message width, FSM
// encoding and the round-robin index arithmetic.
package gpio_link_pkg;

    localparam int MSG_W   = 128;
    localparam int IDX_W   = 3;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } linkState_t;

    function automatic logic [IDX_W-1:0] rrNext(input logic [IDX_W-1:0] idx, input int numReq);
        int n;
        n = int'(idx) + 1;
        if (n >= numReq) n = 0;
        return IDX_W'(n);
    endfunction

    // First set bit of valid at or above ptr, wrapping at numReq; ptr if none set.
    function automatic logic [IDX_W-1:0] rrPick(input logic [MAX_REQ-1:0] valid,
                                                input logic [IDX_W-1:0]   ptr,
                                                input int                 numReq);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % numReq;
            if (k < numReq && !found && valid[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/gpio_link_sync2.sv
// Two-flop synchronizer used for the link's done and received handshakes,
// which arrive asynchronously from the GPIO protocol block.
module gpio_sync2 (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/gpio_link_scheduler.sv
// Round-robin scheduler that shares the GPIO board-to-board link between
// on-chip requesters, with inbound capture and a send timeout.
module gpio_link_scheduler
    import gpio_link_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 1023,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*MSG_W-1:0] req_msg,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic                     link_data_ready,
    output logic [MSG_W-1:0]         link_message_out,
    input  logic                     link_done,
    input  logic                     link_received,
    input  logic [MSG_W-1:0]         link_message_in,
    output logic                     rx_valid,
    output logic [MSG_W-1:0]         rx_msg,
    output logic                     timeout_err,
    output logic                     busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    linkState_t           r_state;
    logic [NUM_REQ-1:0]   r_ack;
    logic                 r_dataReady;
    logic [MSG_W-1:0]     r_msgOut;
    logic                 r_timeoutErr;
    logic                 r_busy;
    logic [IDX_W-1:0]     r_rrPtr;
    logic [IDX_W-1:0]     r_grant;
    logic [CNT_W-1:0]     r_cnt;
    logic [GAP_W-1:0]     r_gapCnt;
    logic                 r_rcvPrev;
    logic                 r_rxValid;
    logic [MSG_W-1:0]     r_rxMsg;

    logic                 w_doneS;
    logic                 w_rcvS;
    logic                 w_rcvRise;
    logic [MAX_REQ-1:0]   w_validPad;
    logic [IDX_W-1:0]     w_pick;
    logic [MSG_W-1:0]     w_pickMsg;
    logic [NUM_REQ-1:0]   w_grantOneHot;

    gpio_sync2 u_syncDone (
        .clock   (clock),
        .reset   (reset),
        .i_async (link_done),
        .o_sync  (w_doneS)
    );

    gpio_sync2 u_syncRcv (
        .clock   (clock),
        .reset   (reset),
        .i_async (link_received),
        .o_sync  (w_rcvS)
    );

    assign w_rcvRise  = w_rcvS & ~r_rcvPrev;
    assign w_validPad = MAX_REQ'(req_valid);
    assign w_pick     = rrPick(w_validPad, r_rrPtr, NUM_REQ);

    always_comb begin
        w_pickMsg     = '0;
        w_grantOneHot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick == IDX_W'(i)) w_pickMsg = req_msg[i*MSG_W +: MSG_W];
            w_grantOneHot[i] = (r_grant == IDX_W'(i));
        end
    end

    // Done beats timeout; either way the pointer moves past the grant so an
    // aborted requester is retried only after the others get a turn.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ack        <= '0;
            r_dataReady  <= 1'b0;
            r_msgOut     <= '0;
            r_timeoutErr <= 1'b0;
            r_busy       <= 1'b0;
            r_rrPtr      <= '0;
            r_grant      <= '0;
            r_cnt        <= '0;
            r_gapCnt     <= '0;
        end else begin
            r_ack        <= '0;
            r_timeoutErr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req_valid && !w_rcvS) begin
                        r_msgOut    <= w_pickMsg;
                        r_grant     <= w_pick;
                        r_cnt       <= '0;
                        r_dataReady <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= SEND;
                    end
                end
                SEND: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_doneS) begin
                        r_ack       <= w_grantOneHot;
                        r_dataReady <= 1'b0;
                        r_rrPtr     <= rrNext(r_grant, NUM_REQ);
                        r_gapCnt    <= '0;
                        r_state     <= GAP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_timeoutErr <= 1'b1;
                        r_dataReady  <= 1'b0;
                        r_rrPtr      <= rrNext(r_grant, NUM_REQ);
                        r_gapCnt     <= '0;
                        r_state      <= GAP;
                    end
                end
                GAP: begin
                    if (r_gapCnt == GAP_W'(GAP_CYCLES - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt + 1'b1;
                    end
                end
                default: begin
                    r_dataReady <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // Inbound capture is independent of the send FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rcvPrev <= 1'b0;
            r_rxValid <= 1'b0;
            r_rxMsg   <= '0;
        end else begin
            r_rcvPrev <= w_rcvS;
            r_rxValid <= w_rcvRise;
            if (w_rcvRise) r_rxMsg <= link_message_in;
        end
    end

    assign req_ack          = r_ack;
    assign link_data_ready  = r_dataReady;
    assign link_message_out = r_msgOut;
    assign timeout_err      = r_timeoutErr;
    assign busy             = r_busy;
    assign rx_valid         = r_rxValid;
    assign rx_msg           = r_rxMsg;

endmodule

// File: tb/tb_gpio_link_scheduler.sv
// Directed bench for gpio_link_scheduler: arbitration order, timeout,
// done/timeout collision, inbound priority and reset during a send.
module tb_gpio_link_scheduler;

    localparam int NR  = 4;
    localparam int TO  = 1023;
    localparam int GAP = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*128-1:0] req_msg;
    logic [NR-1:0]     req_ack;
    logic              link_data_ready;
    logic [127:0]      link_message_out;
    logic              link_done;
    logic              link_received;
    logic [127:0]      link_message_in;
    logic              rx_valid;
    logic [127:0]      rx_msg;
    logic              timeout_err;
    logic              busy;

    logic [127:0] msgs [NR];
    int checkCount = 0;
    int passCount  = 0;
    int ackCount   = 0;
    int rxCount    = 0;
    int toCount    = 0;

    always #5 clock = ~clock;

    gpio_link_scheduler #(.NUM_REQ(NR), .TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_msg          (req_msg),
        .req_ack          (req_ack),
        .link_data_ready  (link_data_ready),
        .link_message_out (link_message_out),
        .link_done        (link_done),
        .link_received    (link_received),
        .link_message_in  (link_message_in),
        .rx_valid         (rx_valid),
        .rx_msg           (rx_msg),
        .timeout_err      (timeout_err),
        .busy             (busy)
    );

    always @(negedge clock) begin
        if (req_ack != '0) ackCount++;
        if (rx_valid)      rxCount++;
        if (timeout_err)   toCount++;
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [NR-1:0] valid);
        req_valid = valid;
    endtask

    task automatic doReset();
        reset         = 1'b1;
        req_valid     = '0;
        link_done     = 1'b0;
        link_received = 1'b0;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic waitReady(input string tag);
        int n;
        n = 0;
        while (!link_data_ready && n < 200) begin
            step();
            n++;
        end
        checkOutput(tag, link_data_ready, 1'b1);
    endtask

    task automatic serveDone(input string tag, input int delay, input logic [NR-1:0] expAck, output int lat);
        repeat (delay) step();
        link_done = 1'b1;
        lat = 0;
        while (req_ack == '0 && lat < 20) begin
            step();
            lat++;
        end
        checkOutput(tag, req_ack, expAck);
        link_done = 1'b0;
    endtask

    initial begin
        int   n;
        int   a0;
        int   r0;
        int   t0;
        int   lat;
        logic sawReady;
        int   order [5];

        msgs[0] = {16{8'hA5}};
        msgs[1] = {16{8'h3C}};
        msgs[2] = {8{16'hBEEF}};
        msgs[3] = {4{32'h0123_4567}};
        for (int i = 0; i < NR; i++) req_msg[i*128 +: 128] = msgs[i];
        link_message_in = '0;
        order = '{0, 1, 2, 3, 0};

        // Reset state
        doReset();
        checkOutput("rst_data_ready", link_data_ready, 1'b0);
        checkOutput("rst_msg_out", link_message_out, 128'h0);
        checkOutput("rst_ack", req_ack, 4'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_rx_valid", rx_valid, 1'b0);
        checkOutput("rst_rx_msg", rx_msg, 128'h0);
        checkOutput("rst_timeout", timeout_err, 1'b0);

        // Single requester, first data_ready one cycle after sampling
        applyStimulus(4'b0001);
        step();
        checkOutput("single_ready_1cyc", link_data_ready, 1'b1);
        checkOutput("single_msg", link_message_out, msgs[0]);
        checkOutput("single_busy", busy, 1'b1);
        serveDone("single_ack", 0, 4'b0001, lat);
        checkOutput("single_ack_latency", lat, 3);
        applyStimulus(4'b0000);
        checkOutput("single_gap1_low", link_data_ready, 1'b0);
        step();
        checkOutput("single_gap2_low", link_data_ready, 1'b0);
        checkOutput("single_gap_busy", busy, 1'b1);
        step();
        checkOutput("single_idle_busy", busy, 1'b0);

        // All four requesting: round-robin order 0,1,2,3,0
        doReset();
        applyStimulus(4'b1111);
        for (int k = 0; k < 5; k++) begin
            waitReady($sformatf("rr_ready_%0d", k));
            checkOutput($sformatf("rr_msg_%0d", k), link_message_out, msgs[order[k]]);
            serveDone($sformatf("rr_ack_%0d", k), 10, 4'(1 << order[k]), lat);
        end
        applyStimulus(4'b0000);

        // Timeout with no done, then the other requester is served
        doReset();
        applyStimulus(4'b0011);
        waitReady("to_ready");
        checkOutput("to_msg0", link_message_out, msgs[0]);
        a0 = ackCount;
        n = 0;
        while (!timeout_err && n < TO + 20) begin
            step();
            n++;
        end
        checkOutput("to_cycle", n, TO);
        checkOutput("to_dr_low", link_data_ready, 1'b0);
        checkOutput("to_no_ack", ackCount - a0, 0);
        waitReady("to_retry_ready");
        checkOutput("to_next_msg1", link_message_out, msgs[1]);
        serveDone("to_next_ack1", 3, 4'b0010, lat);
        waitReady("to_back_ready");
        checkOutput("to_back_msg0", link_message_out, msgs[0]);
        serveDone("to_back_ack0", 3, 4'b0001, lat);
        applyStimulus(4'b0000);

        // done_s and timeout land on the same cycle: done wins
        doReset();
        applyStimulus(4'b0001);
        waitReady("col_ready");
        t0 = toCount;
        n = 0;
        while (n < TO - 3) begin
            step();
            n++;
        end
        link_done = 1'b1;
        while (req_ack == '0 && !timeout_err && n < TO + 10) begin
            step();
            n++;
        end
        checkOutput("col_ack", req_ack, 4'b0001);
        checkOutput("col_timeout", timeout_err, 1'b0);
        checkOutput("col_cycle", n, TO);
        link_done = 1'b0;
        applyStimulus(4'b0000);
        step();
        checkOutput("col_no_to_pulse", toCount - t0, 0);

        // Inbound traffic blocks a pending send until received falls
        doReset();
        r0 = rxCount;
        link_message_in = 128'h1234;
        link_received = 1'b1;
        repeat (3) step();
        applyStimulus(4'b0001);
        sawReady = 1'b0;
        repeat (6) begin
            step();
            if (link_data_ready) sawReady = 1'b1;
        end
        checkOutput("rx_blocks_send", sawReady, 1'b0);
        link_received = 1'b0;
        waitReady("rx_send_after");
        checkOutput("rx_send_msg", link_message_out, msgs[0]);
        checkOutput("rx_valid_once", rxCount - r0, 1);
        checkOutput("rx_msg", rx_msg, 128'h1234);
        serveDone("rx_send_ack", 2, 4'b0001, lat);
        applyStimulus(4'b0000);

        // Reset five cycles into SEND after the pointer has moved
        doReset();
        applyStimulus(4'b0100);
        waitReady("rs_ready2");
        checkOutput("rs_msg2", link_message_out, msgs[2]);
        serveDone("rs_ack2", 2, 4'b0100, lat);
        applyStimulus(4'b0010);
        waitReady("rs_ready1");
        checkOutput("rs_msg1", link_message_out, msgs[1]);
        repeat (5) step();
        a0 = ackCount;
        reset = 1'b1;
        step();
        checkOutput("rs_dr_low", link_data_ready, 1'b0);
        checkOutput("rs_busy", busy, 1'b0);
        checkOutput("rs_ack", req_ack, 4'b0);
        reset = 1'b0;
        applyStimulus(4'b1111);
        waitReady("rs_after_ready");
        checkOutput("rs_ptr_zero", link_message_out, msgs[0]);
        checkOutput("rs_no_ack", ackCount - a0, 0);
        serveDone("rs_after_ack", 2, 4'b0001, lat);
        applyStimulus(4'b0000);
        repeat (4) step();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
